// File: rtl/match_controller_pkg.sv
// Shared definitions for the tank-game match sequencer: state encoding,
// player count and winner codes.
package match_controller_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SPAWN     = 3'd1,
        PLAY      = 3'd2,
        ROUND_END = 3'd3,
        GAME_OVER = 3'd4
    } game_state_e;

    localparam int PLAYER_COUNT = 2;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P0   = 2'b01;
    localparam logic [1:0] WINNER_P1   = 2'b10;

endpackage

// File: rtl/match_controller_fire.sv
// Per-player fire gate: issues a registered one-frame bullet spawn pulse and
// holds off further spawns with a FIRE_COOLDOWN frame down-counter.
module fire_gate #(
    parameter int FIRE_COOLDOWN = 15
) (
    input  logic frameClk,
    input  logic reset_h,
    input  logic i_enable,
    input  logic i_fire_req,
    input  logic i_tank_exists,
    input  logic i_bullet_exists,
    input  logic i_clear,
    output logic o_spawn
);

    localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);

    logic [CD_W-1:0] r_cooldown;
    logic            r_spawn;
    logic            w_fire;

    assign w_fire = i_enable & i_fire_req & i_tank_exists & ~i_bullet_exists
                  & (r_cooldown == '0);

    // Cooldown only matters inside PLAY, and every entry to PLAY passes
    // through a clear, so it is allowed to run down freely elsewhere.
    always_ff @(posedge frameClk) begin
        if (reset_h || i_clear) begin
            r_cooldown <= '0;
            r_spawn    <= 1'b0;
        end else begin
            r_spawn <= w_fire;
            if (w_fire) begin
                r_cooldown <= CD_W'(FIRE_COOLDOWN);
            end else if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - CD_W'(1);
            end
        end
    end

    assign o_spawn = r_spawn;

endmodule

// File: rtl/match_controller.sv
// Frame-rate round sequencer: spawns tanks, gates firing, turns hits into
// kills and score, runs the inter-round delay and detects game over.
module match_controller
    import match_controller_pkg::*;
#(
    parameter int WIN_SCORE     = 5,
    parameter int ROUND_DELAY   = 120,
    parameter int FIRE_COOLDOWN = 15,
    parameter int SCORE_W       = 4
) (
    input  logic               frameClk,
    input  logic               reset_h,
    input  logic               startGame,
    input  logic [1:0]         fireReq,
    input  logic [1:0]         tankHit,
    input  logic [1:0]         tankExists,
    input  logic [1:0]         bulletExists,
    output logic [1:0]         tankSpawn,
    output logic [1:0]         tankKill,
    output logic [1:0]         bulletSpawn,
    output logic               bulletKillAll,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [1:0]         winner,
    output logic               roundActive,
    output logic [2:0]         gameState
);

    localparam int                 DLY_W  = $clog2(ROUND_DELAY + 1);
    localparam logic [SCORE_W-1:0] WIN_SC = SCORE_W'(WIN_SCORE);

    game_state_e        r_state;
    logic [SCORE_W-1:0] r_score0;
    logic [SCORE_W-1:0] r_score1;
    logic [1:0]         r_winner;
    logic [DLY_W-1:0]   r_cnt;
    logic [1:0]         r_tank_spawn;
    logic [1:0]         r_tank_kill;
    logic               r_kill_all;
    logic               r_round_active;

    game_state_e        w_next_state;
    logic [SCORE_W-1:0] w_next_score0;
    logic [SCORE_W-1:0] w_next_score1;
    logic [1:0]         w_next_winner;
    logic [DLY_W-1:0]   w_next_cnt;
    logic [1:0]         w_next_kill;
    logic               w_hit_frame;
    logic               w_entering_spawn;
    logic               w_gate_enable;
    logic [1:0]         w_bullet_spawn;

    always_comb begin
        w_next_state  = r_state;
        w_next_score0 = r_score0;
        w_next_score1 = r_score1;
        w_next_winner = r_winner;
        w_next_cnt    = r_cnt;
        w_next_kill   = 2'b00;
        w_hit_frame   = 1'b0;
        case (r_state)
            IDLE, GAME_OVER: begin
                if (startGame) begin
                    w_next_score0 = '0;
                    w_next_score1 = '0;
                    w_next_winner = WINNER_NONE;
                    w_next_state  = SPAWN;
                end
            end
            SPAWN: w_next_state = PLAY;
            PLAY: begin
                // A hit wins over any fire request in the same frame.
                if (tankHit != 2'b00) begin
                    w_hit_frame = 1'b1;
                    w_next_kill = tankHit;
                    if (tankHit == 2'b01 && r_score1 < WIN_SC) begin
                        w_next_score1 = r_score1 + SCORE_W'(1);
                    end
                    if (tankHit == 2'b10 && r_score0 < WIN_SC) begin
                        w_next_score0 = r_score0 + SCORE_W'(1);
                    end
                    w_next_cnt   = DLY_W'(ROUND_DELAY - 1);
                    w_next_state = ROUND_END;
                end
            end
            ROUND_END: begin
                if (r_cnt == '0) begin
                    if (r_score0 == WIN_SC) begin
                        w_next_winner = WINNER_P0;
                        w_next_state  = GAME_OVER;
                    end else if (r_score1 == WIN_SC) begin
                        w_next_winner = WINNER_P1;
                        w_next_state  = GAME_OVER;
                    end else begin
                        w_next_state = SPAWN;
                    end
                end else begin
                    w_next_cnt = r_cnt - DLY_W'(1);
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // SPAWN always exits to PLAY, so next==SPAWN marks exactly the entry edge.
    assign w_entering_spawn = (w_next_state == SPAWN);
    assign w_gate_enable    = (r_state == PLAY) && !w_hit_frame;

    always_ff @(posedge frameClk) begin
        if (reset_h) begin
            r_state        <= IDLE;
            r_score0       <= '0;
            r_score1       <= '0;
            r_winner       <= WINNER_NONE;
            r_cnt          <= '0;
            r_tank_spawn   <= 2'b00;
            r_tank_kill    <= 2'b00;
            r_kill_all     <= 1'b0;
            r_round_active <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_score0       <= w_next_score0;
            r_score1       <= w_next_score1;
            r_winner       <= w_next_winner;
            r_cnt          <= w_next_cnt;
            r_tank_spawn   <= {2{w_entering_spawn}};
            r_tank_kill    <= w_next_kill;
            r_kill_all     <= w_hit_frame | w_entering_spawn;
            r_round_active <= (w_next_state == PLAY);
        end
    end

    for (genvar g = 0; g < PLAYER_COUNT; g++) begin : g_fire
        fire_gate #(
            .FIRE_COOLDOWN(FIRE_COOLDOWN)
        ) u_fire_gate (
            .frameClk       (frameClk),
            .reset_h        (reset_h),
            .i_enable       (w_gate_enable),
            .i_fire_req     (fireReq[g]),
            .i_tank_exists  (tankExists[g]),
            .i_bullet_exists(bulletExists[g]),
            .i_clear        (w_entering_spawn),
            .o_spawn        (w_bullet_spawn[g])
        );
    end

    assign tankSpawn     = r_tank_spawn;
    assign tankKill      = r_tank_kill;
    assign bulletSpawn   = w_bullet_spawn;
    assign bulletKillAll = r_kill_all;
    assign score0        = r_score0;
    assign score1        = r_score1;
    assign winner        = r_winner;
    assign roundActive   = r_round_active;
    assign gameState     = r_state;

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: a frame-level reference model
// pushes expected outputs; each frame's DUT outputs are popped and compared.
module tb_match_controller;

  localparam int WIN = 2;
  localparam int RD  = 4;
  localparam int FC  = 3;
  localparam int SW  = 4;
  localparam int W   = 21;

  localparam int ST_IDLE  = 0;
  localparam int ST_SPAWN = 1;
  localparam int ST_PLAY  = 2;
  localparam int ST_END   = 3;
  localparam int ST_OVER  = 4;

  logic          frameClk = 1'b0;
  logic          reset_h = 1'b0;
  logic          startGame = 1'b0;
  logic [1:0]    fireReq = 2'b00;
  logic [1:0]    tankHit = 2'b00;
  logic [1:0]    tankExists = 2'b00;
  logic [1:0]    bulletExists = 2'b00;
  logic [1:0]    tankSpawn;
  logic [1:0]    tankKill;
  logic [1:0]    bulletSpawn;
  logic          bulletKillAll;
  logic [SW-1:0] score0;
  logic [SW-1:0] score1;
  logic [1:0]    winner;
  logic          roundActive;
  logic [2:0]    gameState;
  logic [W-1:0]  w_obs;

  int n_total = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  int m_state = ST_IDLE;
  int m_s0 = 0;
  int m_s1 = 0;
  int m_win = 0;
  int m_cnt = 0;
  int m_cd[2] = '{0, 0};

  always #5 frameClk = ~frameClk;

  match_controller #(
    .WIN_SCORE(WIN),
    .ROUND_DELAY(RD),
    .FIRE_COOLDOWN(FC),
    .SCORE_W(SW)
  ) dut (
    .frameClk(frameClk),
    .reset_h(reset_h),
    .startGame(startGame),
    .fireReq(fireReq),
    .tankHit(tankHit),
    .tankExists(tankExists),
    .bulletExists(bulletExists),
    .tankSpawn(tankSpawn),
    .tankKill(tankKill),
    .bulletSpawn(bulletSpawn),
    .bulletKillAll(bulletKillAll),
    .score0(score0),
    .score1(score1),
    .winner(winner),
    .roundActive(roundActive),
    .gameState(gameState)
  );

  assign w_obs = {tankSpawn, tankKill, bulletSpawn, bulletKillAll,
                  score0, score1, winner, roundActive, gameState};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: advances one frame and pushes the outputs it expects.
  task automatic model_step(input logic rst, input logic st, input logic [1:0] fire,
                            input logic [1:0] hit, input logic [1:0] te, input logic [1:0] be);
    logic [1:0] ts, tk, bs, win_code;
    logic ka, ra;
    logic [2:0] st_code;
    logic [SW-1:0] s0_v, s1_v;
    ts = 2'b00; tk = 2'b00; bs = 2'b00; ka = 1'b0;
    if (rst) begin
      m_state = ST_IDLE; m_s0 = 0; m_s1 = 0; m_win = 0; m_cnt = 0;
      m_cd[0] = 0; m_cd[1] = 0;
    end else begin
      case (m_state)
        ST_IDLE, ST_OVER: begin
          if (st) begin
            m_s0 = 0; m_s1 = 0; m_win = 0;
            m_state = ST_SPAWN; ts = 2'b11; ka = 1'b1;
            m_cd[0] = 0; m_cd[1] = 0;
          end
        end
        ST_SPAWN: m_state = ST_PLAY;
        ST_PLAY: begin
          if (hit != 2'b00) begin
            tk = hit; ka = 1'b1;
            if (hit == 2'b01 && m_s1 < WIN) m_s1++;
            if (hit == 2'b10 && m_s0 < WIN) m_s0++;
            m_cnt = RD - 1;
            m_state = ST_END;
          end else begin
            for (int i = 0; i < 2; i++) begin
              if (fire[i] && te[i] && !be[i] && m_cd[i] == 0) begin
                bs[i] = 1'b1;
                m_cd[i] = FC;
              end else if (m_cd[i] > 0) begin
                m_cd[i]--;
              end
            end
          end
        end
        ST_END: begin
          if (m_cnt == 0) begin
            if (m_s0 == WIN) begin
              m_win = 1; m_state = ST_OVER;
            end else if (m_s1 == WIN) begin
              m_win = 2; m_state = ST_OVER;
            end else begin
              m_state = ST_SPAWN; ts = 2'b11; ka = 1'b1;
              m_cd[0] = 0; m_cd[1] = 0;
            end
          end else begin
            m_cnt--;
          end
        end
        default: m_state = ST_IDLE;
      endcase
    end
    ra = (m_state == ST_PLAY);
    s0_v = SW'(m_s0);
    s1_v = SW'(m_s1);
    win_code = 2'(m_win);
    st_code = 3'(m_state);
    exp_q.push_back({ts, tk, bs, ka, s0_v, s1_v, win_code, ra, st_code});
  endtask

  task automatic frame(input string tag, input logic rst, input logic st, input logic [1:0] fire,
                       input logic [1:0] hit, input logic [1:0] te, input logic [1:0] be);
    reset_h = rst; startGame = st; fireReq = fire;
    tankHit = hit; tankExists = te; bulletExists = be;
    model_step(rst, st, fire, hit, te, be);
    @(posedge frameClk);
    #1;
    if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else check(tag, 32'(w_obs), 32'(exp_q.pop_front()));
  endtask

  task automatic idle_frames(input string tag, input int n);
    for (int i = 0; i < n; i++) frame(tag, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00);
  endtask

  // ROUND_END frames with fire/hit/start asserted to show they are ignored.
  task automatic noisy_frames(input string tag, input int n);
    for (int i = 0; i < n; i++) frame(tag, 1'b0, 1'b1, 2'b11, 2'b11, 2'b11, 2'b00);
  endtask

  initial begin
    frame("reset", 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    check("reset_state", 32'(gameState), ST_IDLE);
    idle_frames("idle_hold", 2);

    frame("start", 1'b0, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00);
    check("spawn_tanks", 32'(tankSpawn), 32'd3);
    check("spawn_killall", 32'(bulletKillAll), 32'd1);
    idle_frames("enter_play", 1);
    check("play_active", 32'(roundActive), 32'd1);

    // Held fire: spawn, 3 cooldown frames, re-spawn.
    frame("fire_first", 1'b0, 1'b0, 2'b01, 2'b00, 2'b11, 2'b00);
    check("fire_pulse", 32'(bulletSpawn), 32'd1);
    for (int i = 0; i < 4; i++) frame("fire_held", 1'b0, 1'b0, 2'b01, 2'b00, 2'b11, 2'b00);
    check("fire_refire", 32'(bulletSpawn), 32'd1);
    // Cooldown expires while bullet 0 still alive: no fire until it is gone.
    for (int i = 0; i < 4; i++) frame("fire_blocked", 1'b0, 1'b0, 2'b01, 2'b00, 2'b11, 2'b01);
    frame("fire_after_gone", 1'b0, 1'b0, 2'b01, 2'b00, 2'b11, 2'b00);
    check("fire_after_gone_pulse", 32'(bulletSpawn), 32'd1);
    frame("fire_no_tank", 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00);

    frame("hit_p0", 1'b0, 1'b0, 2'b00, 2'b01, 2'b11, 2'b00);
    check("hit_score1", 32'(score1), 32'd1);
    check("hit_kill", 32'(tankKill), 32'd1);
    noisy_frames("round_end", 3);
    frame("respawn", 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00);
    check("respawn_state", 32'(gameState), ST_SPAWN);
    idle_frames("play2", 1);

    frame("draw", 1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00);
    check("draw_nofire", 32'(bulletSpawn), 32'd0);
    check("draw_kill", 32'(tankKill), 32'd3);
    noisy_frames("draw_end", 3);
    idle_frames("play3", 2);

    frame("hit_p1_a", 1'b0, 1'b0, 2'b00, 2'b10, 2'b11, 2'b00);
    idle_frames("end_a", 5);
    frame("hit_p1_b", 1'b0, 1'b0, 2'b00, 2'b10, 2'b11, 2'b00);
    check("score0_win", 32'(score0), WIN);
    idle_frames("end_b", 4);
    check("game_over", 32'(gameState), ST_OVER);
    check("winner_p0", 32'(winner), 32'd1);
    for (int i = 0; i < 3; i++) frame("over_hit", 1'b0, 1'b0, 2'b11, 2'b01, 2'b11, 2'b00);
    frame("restart", 1'b0, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00);
    check("restart_scores", 32'({score0, score1, winner}), 32'd0);
    idle_frames("play4", 1);

    frame("hit_before_rst", 1'b0, 1'b0, 2'b00, 2'b01, 2'b11, 2'b00);
    idle_frames("end_cnt2", 1);
    frame("mid_reset", 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00);
    check("mid_reset_outs", 32'(w_obs), 32'd0);
    idle_frames("stay_idle", 3);

    // Random traffic: the model tracks every frame.
    for (int i = 0; i < 600; i++) begin
      frame("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
